// File: rtl/counter_cmd_responder.sv
// Command responder: executes LOAD/INC/READ/NOP on a wrapping counter and
// returns one {op, count, wrap} response per accepted command through a FIFO.
module counter_cmd_responder #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_wrap,
    output logic [1:0]       rsp_op,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // req_ready and rsp_valid are registered, so neither depends on inputs
    // of the current cycle; a pop never frees a slot for the same-cycle request.

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = WIDTH + 3;

    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr_n;
    logic [PW-1:0]   rd_ptr_n;
    logic [PW-1:0]   occ;
    logic            push;
    logic            pop;
    logic            empty;
    logic            empty_n;
    logic            full_n;
    logic [WIDTH-1:0] exec_count;
    logic            exec_wrap;
    logic [EW-1:0]   push_entry;
    logic [EW-1:0]   head_n;
    logic            head_load;
    state_t          state_n;

    assign push = req_valid && req_ready;
    assign pop  = rsp_valid && rsp_ready;

    assign occ      = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign wr_ptr_n = wr_ptr + PW'(push);
    assign rd_ptr_n = rd_ptr + PW'(pop);

    // Pointers carry one extra bit so full and empty differ only in the MSB.
    assign empty_n = (wr_ptr_n == rd_ptr_n);
    assign full_n  = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                     (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

    always_comb begin
        exec_count = count;
        exec_wrap  = 1'b0;
        case (req_op)
            OP_LOAD: exec_count = req_data;
            OP_INC: begin
                exec_count = count + {{(WIDTH-1){1'b0}}, 1'b1};
                exec_wrap  = &count;
            end
            default: ;
        endcase
    end

    assign push_entry = {req_op, exec_wrap, exec_count};

    // The head is held in output registers; work out what it becomes next.
    always_comb begin
        head_load = 1'b0;
        head_n    = push_entry;
        if (pop) begin
            if (occ == PW'(1)) begin
                head_load = push;
                head_n    = push_entry;
            end else begin
                head_load = 1'b1;
                head_n    = mem[rd_ptr_n[AW-1:0]];
            end
        end else if (empty && push) begin
            head_load = 1'b1;
            head_n    = push_entry;
        end
    end

    always_comb begin
        state_n = S_BUSY;
        if (empty_n)
            state_n = S_IDLE;
        else if (full_n)
            state_n = S_FULL;
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_wrap  <= 1'b0;
            rsp_op    <= 2'd0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            req_ready <= (state_n != S_FULL);
            rsp_valid <= (state_n != S_IDLE);
            if (push)
                count <= exec_count;
            if (head_load)
                {rsp_op, rsp_wrap, rsp_data} <= head_n;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_counter_cmd_responder.sv
// Bench for counter_cmd_responder: directed scenarios plus random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_counter_cmd_responder;

    localparam int WIDTH = 7;
    localparam int DEPTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_wrap;
    logic [1:0]       rsp_op;
    logic [WIDTH-1:0] count;
    logic [1:0]       state_dbg;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected responses packed as {op, wrap, data}.
    logic [WIDTH+2:0] exp_q[$];
    int               m_count;

    counter_cmd_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_wrap  (rsp_wrap),
        .rsp_op    (rsp_op),
        .count     (count),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        int               sz;
        bit               do_pop;
        bit               do_push;
        bit               wrap;
        logic [WIDTH+2:0] e;
        if (rst) begin
            exp_q.delete();
            m_count = 0;
        end else begin
            sz      = exp_q.size();
            do_pop  = (sz != 0) && rsp_ready;
            do_push = req_valid && (sz < DEPTH);
            e       = '0;
            if (do_push) begin
                wrap = 1'b0;
                if (req_op == 2'd1) begin
                    m_count = int'(req_data);
                end else if (req_op == 2'd2) begin
                    wrap    = (m_count == MAXV);
                    m_count = (m_count + 1) % (MAXV + 1);
                end
                e = {req_op, wrap, WIDTH'(m_count)};
            end
            if (do_pop)
                void'(exp_q.pop_front());
            if (do_push)
                exp_q.push_back(e);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        int sz;
        int exp_state;
        if (!rst) begin
            sz = exp_q.size();
            exp_state = (sz == 0) ? 0 : ((sz == DEPTH) ? 2 : 1);
            check("req_ready", int'(req_ready), int'(sz < DEPTH));
            check("rsp_valid", int'(rsp_valid), int'(sz != 0));
            check("count", int'(count), m_count);
            check("state", int'(state_dbg), exp_state);
            if (rsp_valid && sz != 0) begin
                check("rsp_data", int'(rsp_data), int'(exp_q[0][WIDTH-1:0]));
                check("rsp_wrap", int'(rsp_wrap), int'(exp_q[0][WIDTH]));
                check("rsp_op", int'(rsp_op), int'(exp_q[0][WIDTH+2:WIDTH+1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done)
            check("accept_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_rsp_data"}, int'(rsp_data), 0);
        check({tag, "_rsp_wrap"}, int'(rsp_wrap), 0);
        check({tag, "_rsp_op"}, int'(rsp_op), 0);
        check({tag, "_req_ready"}, int'(req_ready), 1);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_count"}, int'(count), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    bit rand_done;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_data  = '0;
        rsp_ready = 1'b1;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // INC x3 with the consumer always ready
        for (int i = 0; i < 3; i++) send(2'd2, '0);
        idle(3);

        // LOAD all-ones then INC wraps to zero
        send(2'd1, 7'd127);
        send(2'd2, '0);
        idle(3);

        // Stall the consumer: four fit, the fifth waits for a pop
        rsp_ready = 1'b0;
        fork
            for (int i = 0; i < 5; i++) send(2'd2, '0);
            begin
                idle(10);
                rsp_ready = 1'b1;
            end
        join
        idle(4);

        // Steady occupancy of one: push and pop every cycle
        for (int i = 0; i < 21; i++) send(2'd2, '0);
        idle(3);

        // LOAD / READ / NOP echo
        send(2'd1, 7'h55);
        send(2'd3, 7'h12);
        send(2'd0, 7'h3c);
        idle(3);

        // Reset with three queued responses and a request on the port
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'd2, '0);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_data  = 7'h2a;
        do_reset();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check_reset_outputs("midreset");
        idle(3);

        // Random traffic with a randomly stalling consumer
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(2'($urandom_range(0, 3)), WIDTH'($urandom_range(0, MAXV)));
                    if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
                    if ($urandom_range(0, 120) == 0) do_reset();
                end
                rand_done = 1'b1;
            end
            while (!rand_done) begin
                @(posedge clk);
                #1;
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        join

        rsp_ready = 1'b1;
        idle(DEPTH + 3);
        @(negedge clk);
        check("drained_rsp_valid", int'(rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
